// File: rtl/rf_pkg.sv
// Shared register-file constants and helpers for the writeback arbiter.
package rf_pkg;

   localparam int unsigned RF_AW       = 5;
   localparam int unsigned RF_DW       = 32;
   localparam int unsigned RF_NREGS    = 32;
   localparam logic [RF_AW-1:0] RF_ZERO_REG = '0;

   // Grant index width covers up to four requesters.
   localparam int unsigned GID_W = 2;

   typedef logic [RF_NREGS-1:0] reg_mask_t;

   function automatic reg_mask_t onehot_reg(input logic [RF_AW-1:0] addr);
      reg_mask_t mask;
      mask       = '0;
      mask[addr] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester handshake, register-file write port and hazard vector of the writeback arbiter.
interface rf_write_arbiter_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 5,
   parameter int unsigned DW   = 32
);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;

   logic               rf_we;
   logic [AW-1:0]      rf_wa;
   logic [DW-1:0]      rf_wd;
   logic [1:0]         grant_id;
   logic               grant_vld;
   logic [2**AW-1:0]   busy_vec;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, rf_we, rf_wa, rf_wd, grant_id, grant_vld, busy_vec
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, rf_we, rf_wa, rf_wd, grant_id, grant_vld, busy_vec
   );

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps ascending.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [GID_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [GID_W-1:0] gnt_idx,
   output logic             gnt_any
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      // First pass covers ptr..NREQ-1, second pass the wrapped part 0..ptr-1.
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!gnt_any && req[j] && (j >= 32'(ptr))) begin
            gnt[j]  = 1'b1;
            gnt_idx = GID_W'(j);
            gnt_any = 1'b1;
         end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!gnt_any && req[j] && (j < 32'(ptr))) begin
            gnt[j]  = 1'b1;
            gnt_idx = GID_W'(j);
            gnt_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port among NREQ writeback requesters, each with a one-entry slot.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = RF_AW,
   parameter int unsigned DW   = RF_DW
) (
   input logic               clk,
   input logic               rst_n,
   rf_write_arbiter_if.slave bus
);

   localparam int unsigned NREGS = 2 ** AW;

   logic [NREQ-1:0]  full_q, full_d;
   logic [AW-1:0]    addr_q [NREQ];
   logic [DW-1:0]    data_q [NREQ];
   logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [NREQ-1:0]  gnt_oh;
   logic [GID_W-1:0] gnt_idx;
   logic             gnt_any;
   logic [NREQ-1:0]  ready;
   logic [NREQ-1:0]  accept;
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_data;
   logic [NREGS-1:0] busy;

   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr_arbiter (
      .req    (full_q),
      .ptr    (rr_ptr_q),
      .gnt    (gnt_oh),
      .gnt_idx(gnt_idx),
      .gnt_any(gnt_any)
   );

   // A slot being retired this cycle can take a new write on the same edge.
   always_comb begin
      ready  = ~full_q | gnt_oh;
      accept = bus.req_valid & ready;
      full_d = (full_q & ~gnt_oh) | accept;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_any) begin
         rr_ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q   <= '0;
         rr_ptr_q <= '0;
         for (int i = 0; i < NREQ; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         full_q   <= full_d;
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
               addr_q[i] <= bus.req_addr[i*AW +: AW];
               data_q[i] <= bus.req_data[i*DW +: DW];
            end
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_oh[i]) begin
            sel_addr = addr_q[i];
            sel_data = data_q[i];
         end
      end
   end

   // Register 0 writes still retire through a grant, but never assert the write enable.
   always_comb begin
      bus.req_ready = ready;
      bus.grant_vld = gnt_any;
      bus.grant_id  = gnt_idx;
      bus.rf_we     = gnt_any && (sel_addr != AW'(RF_ZERO_REG));
      bus.rf_wa     = sel_addr;
      bus.rf_wd     = sel_data;
      bus.busy_vec  = busy;
   end

   if (AW == RF_AW) begin : g_busy_pkg
      always_comb begin
         busy = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (full_q[i]) begin
               busy = busy | onehot_reg(addr_q[i]);
            end
         end
         busy[RF_ZERO_REG] = 1'b0;
      end
   end else begin : g_busy_generic
      always_comb begin
         busy = '0;
         for (int i = 0; i < NREQ; i++) begin
            for (int unsigned r = 1; r < NREGS; r++) begin
               if (full_q[i] && (addr_q[i] == AW'(r))) begin
                  busy[r] = 1'b1;
               end
            end
         end
      end
   end

endmodule
